// File: rtl/fpcvt_pkg.sv
// Shared types, default widths and the width-legality check for fpcvt_seq.
package fpcvt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int DEF_DW = 12;
    localparam int DEF_EW = 3;
    localparam int DEF_FW = 4;

    // The integer must fit exactly: FW significand bits plus one shift per exponent step.
    function automatic bit width_ok(input int dw, input int ew, input int fw);
        return dw == fw + (1 << ew);
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// Rounding of the normalised significand, including the carry into the exponent.
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int EW = DEF_EW,
    parameter int FW = DEF_FW
) (
    input  logic [FW-1:0] f0,
    input  logic          rb,
    input  logic [EW-1:0] exp_in,
    input  logic          mode,
    output logic [FW-1:0] f,
    output logic [EW-1:0] e,
    output logic          ovf
);

    // Round half up on magnitude; an all-ones carry renormalises or saturates.
    always_comb begin
        f   = f0;
        e   = exp_in;
        ovf = 1'b0;
        if (mode && rb) begin
            if (!(&f0)) begin
                f = f0 + FW'(1);
            end else if (!(&exp_in)) begin
                f = FW'(1) << (FW - 1);
                e = exp_in + EW'(1);
            end else begin
                f   = '1;
                ovf = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// Iterative integer-to-float converter: one normalising shift per clock, then round.
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int EW = DEF_EW,
    parameter int FW = DEF_FW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    input  logic          rnd_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [FW-1:0] F,
    output logic          sat
);

    generate
        if (!width_ok(DW, EW, FW)) begin : g_bad_width
            $error("fpcvt_seq: DW must equal FW + 2**EW");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [DW-2:0]   mag_q;
    logic [EW-1:0]   exp_q;
    logic            mode_q;
    logic            sign_q;
    logic            clamp_q;
    logic [DW-1:0]   d_neg;
    logic            accept;
    logic            norm_done;
    logic [FW-1:0]   r_f;
    logic [EW-1:0]   r_e;
    logic            r_ovf;

    assign d_neg     = -D;
    assign accept    = (state_q == IDLE) && in_valid && in_ready;
    assign norm_done = mag_q[DW-2] || (exp_q == '0);

    fpcvt_round #(.EW(EW), .FW(FW)) u_round (
        .f0     (mag_q[DW-2 -: FW]),
        .rb     (mag_q[DW-2-FW]),
        .exp_in (exp_q),
        .mode   (mode_q),
        .f      (r_f),
        .e      (r_e),
        .ovf    (r_ovf)
    );

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: normalise until the MSB is set or the exponent bottoms out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)     state_d = NORM;
            NORM: if (norm_done)  state_d = RND;
            RND:                  state_d = OUT;
            OUT:  if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Working datapath: capture magnitude on accept, shift while normalising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= '0;
            exp_q   <= '0;
            mode_q  <= 1'b0;
            sign_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else if (accept) begin
            sign_q <= D[DW-1];
            exp_q  <= '1;
            mode_q <= rnd_mode;
            // The most negative input has no positive twin; clamp and flag it.
            if (D == {1'b1, {(DW-1){1'b0}}}) begin
                mag_q   <= '1;
                clamp_q <= 1'b1;
            end else begin
                mag_q   <= D[DW-1] ? d_neg[DW-2:0] : D[DW-2:0];
                clamp_q <= 1'b0;
            end
        end else if (state_q == NORM && !norm_done) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - EW'(1);
        end
    end

    // Result registers: loaded once when rounding completes, held through OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S         <= 1'b0;
            E         <= '0;
            F         <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (state_q == RND) begin
            S         <= sign_q;
            E         <= r_e;
            F         <= r_f;
            sat       <= clamp_q | r_ovf;
            out_valid <= 1'b1;
        end else if (state_q == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Registered ready so it stays low while reset is held and rises after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready <= 1'b0;
        else     in_ready <= (state_d == IDLE);
    end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed checks of fpcvt_seq at default widths and at DW=20/EW=4/FW=4.
module tb_fpcvt_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-width instance
    logic        vld_a = 1'b0, rdy_a, rnd_a = 1'b0, ov_a, ordy_a = 1'b0, s_a, sat_a;
    logic [11:0] d_a = '0;
    logic [2:0]  e_a;
    logic [3:0]  f_a;

    // Wide instance
    logic        vld_b = 1'b0, rdy_b, rnd_b = 1'b0, ov_b, ordy_b = 1'b0, s_b, sat_b;
    logic [19:0] d_b = '0;
    logic [3:0]  e_b;
    logic [3:0]  f_b;

    int n_cmp = 0;
    int n_bad = 0;

    fpcvt_seq dut_a (
        .clk(clk), .rst(rst), .in_valid(vld_a), .in_ready(rdy_a), .D(d_a),
        .rnd_mode(rnd_a), .out_valid(ov_a), .out_ready(ordy_a),
        .S(s_a), .E(e_a), .F(f_a), .sat(sat_a)
    );

    fpcvt_seq #(.DW(20), .EW(4), .FW(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vld_b), .in_ready(rdy_b), .D(d_b),
        .rnd_mode(rnd_b), .out_valid(ov_b), .out_ready(ordy_b),
        .S(s_b), .E(e_b), .F(f_b), .sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // Accept one input on dut_a and wait (bounded) for its result.
    task automatic run_a(input logic [11:0] d, input logic rnd, output int lat);
        int w = 0;
        while (!rdy_a && w < 20) begin @(posedge clk); #1; w++; end
        chk("a.in_ready", rdy_a, 1);
        d_a = d; rnd_a = rnd; vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0; d_a = ~d; rnd_a = ~rnd;
        lat = 0;
        while (!ov_a && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("a.out_valid", ov_a, 1);
    endtask

    task automatic ack_a();
        ordy_a = 1'b1;
        @(posedge clk); #1;
        ordy_a = 1'b0;
        chk("a.ack.out_valid", ov_a, 0);
        chk("a.ack.in_ready", rdy_a, 1);
    endtask

    task automatic conv_a(input string tag, input logic [11:0] d, input logic rnd,
                          input int s, input int e, input int f, input int st, input int lat_exp);
        int lat;
        run_a(d, rnd, lat);
        chk({tag, ".S"}, s_a, s);
        chk({tag, ".E"}, e_a, e);
        chk({tag, ".F"}, f_a, f);
        chk({tag, ".sat"}, sat_a, st);
        if (lat_exp >= 0) chk({tag, ".lat"}, lat, lat_exp);
        ack_a();
    endtask

    task automatic conv_b(input string tag, input logic [19:0] d, input logic rnd,
                          input int s, input int e, input int f, input int st, input int lat_exp);
        int w = 0;
        int lat = 0;
        while (!rdy_b && w < 20) begin @(posedge clk); #1; w++; end
        chk({tag, ".in_ready"}, rdy_b, 1);
        d_b = d; rnd_b = rnd; vld_b = 1'b1;
        @(posedge clk); #1;
        vld_b = 1'b0; d_b = '0;
        while (!ov_b && lat < 30) begin @(posedge clk); #1; lat++; end
        chk({tag, ".out_valid"}, ov_b, 1);
        chk({tag, ".S"}, s_b, s);
        chk({tag, ".E"}, e_b, e);
        chk({tag, ".F"}, f_b, f);
        chk({tag, ".sat"}, sat_b, st);
        if (lat_exp >= 0) chk({tag, ".lat"}, lat, lat_exp);
        ordy_b = 1'b1;
        @(posedge clk); #1;
        ordy_b = 1'b0;
        chk({tag, ".ack"}, ov_b, 0);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset state
        #23;
        chk("rst.out_valid", ov_a, 0);
        chk("rst.in_ready", rdy_a, 0);
        chk("rst.S", s_a, 0);
        chk("rst.E", e_a, 0);
        chk("rst.F", f_a, 0);
        chk("rst.sat", sat_a, 0);
        chk("rst.b.in_ready", rdy_b, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rel.in_ready", rdy_a, 1);

        // Saturation / rounding near the top
        conv_a("p2047",  12'd2047, 1'b1, 0, 7, 15, 1, 2);
        conv_a("p1919r", 12'd1919, 1'b1, 0, 7, 15, 0, -1);
        conv_a("p1792",  12'd1792, 1'b1, 0, 7, 14, 0, -1);
        conv_a("p1919t", 12'd1919, 1'b0, 0, 7, 14, 0, -1);
        // Mid-range, sign handling, carry into exponent
        conv_a("p422",   12'd422,  1'b1, 0, 5, 13, 0, 4);
        conv_a("m422",   -12'sd422, 1'b1, 1, 5, 13, 0, 4);
        conv_a("p125r",  12'd125,  1'b1, 0, 4, 8,  0, 6);
        conv_a("p125t",  12'd125,  1'b0, 0, 3, 15, 0, 6);
        // Exponent floor and extremes
        conv_a("zero",   12'd0,    1'b1, 0, 0, 0,  0, 9);
        conv_a("p1",     12'd1,    1'b1, 0, 0, 1,  0, 9);
        conv_a("m1",     12'hFFF,  1'b1, 1, 0, 1,  0, 9);
        conv_a("m2048",  12'h800,  1'b1, 1, 7, 15, 1, 2);

        // Backpressure: result held, new input ignored
        run_a(12'd422, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin d_a = 12'd5; rnd_a = 1'b0; vld_a = 1'b1; end
            @(posedge clk); #1;
            vld_a = 1'b0;
            chk("bp.out_valid", ov_a, 1);
            chk("bp.in_ready", rdy_a, 0);
            chk("bp.S", s_a, 0);
            chk("bp.E", e_a, 5);
            chk("bp.F", f_a, 13);
        end
        ack_a();
        conv_a("bp.next", 12'd125, 1'b1, 0, 4, 8, 0, 6);

        // Reset during NORM discards the conversion
        d_a = 12'd1; rnd_a = 1'b1; vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstnorm.out_valid", ov_a, 0);
        chk("rstnorm.in_ready", rdy_a, 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov_a) seen++;
        end
        chk("rstnorm.no_output", seen, 0);
        chk("rstnorm.idle", rdy_a, 1);
        conv_a("rstnorm.p422", 12'd422, 1'b1, 0, 5, 13, 0, 4);

        // Reset while a result is being presented
        run_a(12'd125, 1'b1, lat);
        #2 rst = 1'b1;
        #1;
        chk("rstout.out_valid", ov_a, 0);
        chk("rstout.E", e_a, 0);
        chk("rstout.F", f_a, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rstout.in_ready", rdy_a, 1);

        // Wide configuration
        conv_b("b1000r", 20'd1000,  1'b1, 0, 7,  8,  0, 11);
        conv_b("b1000t", 20'd1000,  1'b0, 0, 6,  15, 0, 11);
        conv_b("bmin",   20'h80000, 1'b1, 1, 15, 15, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
